jt12_timer_ctrl: RTL
====================

# jt12_timer_ctrl

CPU-side register front end for the timer pair: decodes YM2612 part-0 writes to 0x24–0x27 into timer values, load/enable/clear controls and channel-3 mode. It sits directly upstream of the timer block and also consumes its flags and Timer A overflow. From these it produces the status byte, the busy flag and the CSM key-on pulse for channel 3.

## Interface
Parameters:
- BUSY_CYCLES, 32, number of clk_en ticks busy stays high after a data write
- BCW, 6, width of the busy counter; must satisfy 2^BCW > BUSY_CYCLES

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  chip clock enable
- zero  in  1  once-per-sample strobe, qualified by clk_en
- cpu_cs_n, cpu_wr_n  in  1 each  bus strobes, active-low
- cpu_addr  in  2  {A1,A0}
- cpu_din  in  8  write data
- cpu_dout  out  8  status: {busy, 5'b0, flag_B, flag_A}
- flag_A, flag_B, overflow_A  in  1 each  from timers
- value_A  out  10  Timer A start value
- value_B  out  8  Timer B start value
- load_A, load_B, enable_irq_A, enable_irq_B  out  1 each  level controls
- clr_flag_A, clr_flag_B  out  1 each  one-clk pulses
- ch3_mode  out  2  reg 0x27[7:6]
- csm_keyon  out  1  CSM key-on for channel 3
- busy  out  1  write-busy flag

## Operation
- Write event: cpu_cs_n=0 and cpu_wr_n=0 at a clk edge, with the same condition false at the previous edge (registered strobe, rising edge of the active condition). Write detection is not gated by clk_en.
- A0=0 write: latch {A1, cpu_din} as the 9-bit address.
- A0=1 write: applies to the latched address only if its A1 bit is 0. It sets busy and reloads the busy counter.
  - 0x24: value_A[9:2] = din.
  - 0x25: value_A[1:0] = din[1:0].
  - 0x26: value_B = din.
  - 0x27: ch3_mode=din[7:6], enable_irq_B=din[3], enable_irq_A=din[2], load_B=din[1], load_A=din[0].
  - 0x27 also: din[5] pulses clr_flag_B and din[4] pulses clr_flag_A for exactly one clk. These bits are not stored.
- A1=1 data writes and any other address: busy only; no register change.
- Busy counter: loaded with BUSY_CYCLES on a data write; decrements on each clk_en; busy=0 when it reaches 0. A write while busy restarts the count.
- cpu_dout is combinational from busy, flag_A and flag_B, independent of the strobes.
- CSM: at a clk edge with clk_en and zero and overflow_A and ch3_mode==2'b10, csm_keyon goes high. It clears at the next clk_en&&zero edge, so it lasts one sample period. ch3_mode 2'b01 or 2'b11 never raises it.

## Timing
- Reset: every output register is 0, including value_A, value_B, loads, enables, ch3_mode, clr pulses, csm_keyon and busy. The address latch and the strobe history are also 0.
- Register outputs change on the clk edge that detects the write; zero added latency.
- clr_flag_x is high for the single clk following that edge.
- busy rises on the write edge and falls at the clk_en edge where the counter hits 0, i.e. after BUSY_CYCLES clk_en ticks.
- An address write and a data write in consecutive clk cycles both take effect. A strobe held low counts as one write.
- csm_keyon and a 0x27 write on the same edge: csm_keyon uses the ch3_mode value before the write.
- rst_n asserted mid-count clears busy immediately (asynchronous).

## Structure
- Package jt12_timer_pkg:
  - address constants REG_TA_HI=8'h24, REG_TA_LO=8'h25, REG_TB=8'h26, REG_TCTL=8'h27
  - CH3_CSM=2'b10
  - status bit positions
- Sub-module jt12_busy_cnt: reload, clk_en-gated down-count, busy output.

## Test plan
- Reset: release rst_n, no writes -> all outputs 0, cpu_dout=8'h00.
- Timer A value: addr 0x24, data 8'hA5, addr 0x25, data 8'h03 -> value_A=10'h297. busy high for 32 clk_en ticks after each data write, then 0.
- Control register: addr 0x27, data 8'h3F -> load_A=load_B=1, enable_irq_A=enable_irq_B=1, clr_flag_A/B one-clk pulses. A readback write of 8'h0F leaves no clr pulse.
- Part 1 ignored: A1=1 addr 0x26, data 8'h55 -> value_B unchanged at 0, busy still asserted.
- CSM: ch3_mode=2'b10, drive overflow_A with clk_en&&zero -> csm_keyon high for exactly one zero period. With ch3_mode=2'b01 -> csm_keyon stays 0.
- Busy restart: second data write 10 clk_en ticks into busy -> busy stays high 32 ticks from the second write. Async rst_n mid-busy -> busy=0 immediately.

Source files
------------

// File: rtl/jt12_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt12_timer_pkg
// Brief    : Register addresses, CSM mode code and status bit positions for
//            the YM2612 timer register front end.
// Revision : 1.0
// ============================================================================
package jt12_timer_pkg;

    localparam logic [7:0] REG_TA_HI = 8'h24;
    localparam logic [7:0] REG_TA_LO = 8'h25;
    localparam logic [7:0] REG_TB    = 8'h26;
    localparam logic [7:0] REG_TCTL  = 8'h27;

    localparam logic [1:0] CH3_CSM   = 2'b10;

    localparam int STAT_BUSY   = 7;
    localparam int STAT_FLAG_B = 1;
    localparam int STAT_FLAG_A = 0;

    // Field layout of a write to register 0x27
    typedef struct packed {
        logic [1:0] ch3_mode;
        logic       clr_b;
        logic       clr_a;
        logic       irq_b;
        logic       irq_a;
        logic       load_b;
        logic       load_a;
    } tctl_t;

endpackage
`default_nettype wire

// File: rtl/jt12_busy_cnt.sv
`default_nettype none
// ============================================================================
// Module   : jt12_busy_cnt
// Brief    : Write-busy counter: reloads on a data write, counts down on
//            clk_en and reports busy while non-zero.
// Revision : 1.0
// ============================================================================
module jt12_busy_cnt #(
    parameter int BUSY_CYCLES = 32,
    parameter int BCW         = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic reload,
    output logic busy
);

    localparam logic [BCW-1:0] C_LOAD = BCW'(BUSY_CYCLES);
    localparam logic [BCW-1:0] C_ONE  = BCW'(1);

    logic [BCW-1:0] r_cnt;

    // Reload wins over the tick so a write while busy restarts the full count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (reload) begin
            r_cnt <= C_LOAD;
        end else if (clk_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/jt12_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jt12_timer_ctrl
// Brief    : CPU register front end for the timer pair: decodes 0x24-0x27,
//            drives status byte, busy flag and the CSM key-on for channel 3.
// Revision : 1.0
// ============================================================================
module jt12_timer_ctrl #(
    parameter int BUSY_CYCLES = 32,
    parameter int BCW         = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       zero,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic [1:0] ch3_mode,
    output logic       csm_keyon,
    output logic       busy
);
    import jt12_timer_pkg::*;

    logic       w_wr_act;
    logic       w_wr_ev;
    logic       w_addr_wr;
    logic       w_data_wr;
    logic       w_reg_wr;
    logic       r_wr_prev;
    logic [8:0] r_addr;
    tctl_t      w_tctl;

    // A strobe held low over several clocks is a single write
    assign w_wr_act  = !cpu_cs_n && !cpu_wr_n;
    assign w_wr_ev   = w_wr_act && !r_wr_prev;
    assign w_addr_wr = w_wr_ev && !cpu_addr[0];
    assign w_data_wr = w_wr_ev &&  cpu_addr[0];
    assign w_reg_wr  = w_data_wr && !cpu_addr[1] && !r_addr[8];
    assign w_tctl    = tctl_t'(cpu_din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_prev <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_wr_prev <= w_wr_act;
            if (w_addr_wr) begin
                r_addr <= {cpu_addr[1], cpu_din};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_A      <= '0;
            value_B      <= '0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            ch3_mode     <= '0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
        end else begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (w_reg_wr) begin
                case (r_addr[7:0])
                    REG_TA_HI: value_A[9:2] <= cpu_din;
                    REG_TA_LO: value_A[1:0] <= cpu_din[1:0];
                    REG_TB:    value_B      <= cpu_din;
                    REG_TCTL: begin
                        ch3_mode     <= w_tctl.ch3_mode;
                        enable_irq_B <= w_tctl.irq_b;
                        enable_irq_A <= w_tctl.irq_a;
                        load_B       <= w_tctl.load_b;
                        load_A       <= w_tctl.load_a;
                        clr_flag_B   <= w_tctl.clr_b;
                        clr_flag_A   <= w_tctl.clr_a;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Mode compare sees the pre-write ch3_mode when a 0x27 write lands on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csm_keyon <= 1'b0;
        end else if (clk_en && zero) begin
            csm_keyon <= overflow_A && (ch3_mode == CH3_CSM);
        end
    end

    jt12_busy_cnt #(
        .BUSY_CYCLES (BUSY_CYCLES),
        .BCW         (BCW)
    ) u_busy_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .reload (w_data_wr),
        .busy   (busy)
    );

    always_comb begin
        cpu_dout              = '0;
        cpu_dout[STAT_BUSY]   = busy;
        cpu_dout[STAT_FLAG_B] = flag_B;
        cpu_dout[STAT_FLAG_A] = flag_A;
    end

endmodule
`default_nettype wire
